approx_adder_error_monitor32: RTL and testbench

APPROX_ADDER_ERROR_MONITOR32 -- requirements
Module: approx_adder_error_monitor32

---
 rtl/approx_adder_error_monitor32.sv | 91 +++++++++
 tb/tb_approx_adder_error_monitor32.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_error_monitor32.sv
// approx_adder_error_monitor32: accumulates error statistics of an approximate
// 32-bit adder over a window of N samples, in a two-stage pipeline.
module approx_adder_error_monitor32 #(
   parameter int ACC_W = 48
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [15:0]      num_samples_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [31:0]      add1_i,
   input  logic [31:0]      add2_i,
   input  logic [32:0]      approx_i,
   output logic [15:0]      sample_cnt_o,
   output logic [15:0]      err_cnt_o,
   output logic [32:0]      max_ed_o,
   output logic [ACC_W-1:0] sum_ed_o,
   output logic             busy_o,
   output logic             done_o
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   state_e state_q, state_d;
   logic [15:0] n_q, n_d, acc_q, acc_d, cnt_q, cnt_d, err_q, err_d;
   logic [32:0] s1_ed_q, s1_ed_d, max_q, max_d, exact;
   logic [33:0] diff;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [ACC_W:0] sum_w;
   logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, start_ok, take, last;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         n_q     <= '0;
         acc_q   <= '0;
         s1_v_q  <= 1'b0;
         s2_v_q  <= 1'b0;
         s1_ed_q <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         max_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         s1_v_q  <= s1_v_d;
         s2_v_q  <= s2_v_d;
         s1_ed_q <= s1_ed_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
      end
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start_ok) state_d = (num_samples_i == 16'd0) ? DRAIN : RUN;
         RUN:        if (last) state_d = DRAIN;
         DRAIN:      if (!s1_v_q && !s2_v_q) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end
   always_comb begin
      ready_o      = state_q == RUN;
      busy_o       = state_q == RUN || state_q == DRAIN;
      done_o       = state_q == DONE;
      sample_cnt_o = cnt_q;
      err_cnt_o    = err_q;
      max_ed_o     = max_q;
      sum_ed_o     = sum_q;
   end
   // Stage 1 forms the error distance; stage 2 folds it into the statistics.
   always_comb begin
      start_ok = start_i && (state_q == IDLE || state_q == DONE);
      take     = valid_i && state_q == RUN;
      last     = take && (acc_q + 16'd1 == n_q);
      exact    = {1'b0, add1_i} + {1'b0, add2_i};
      diff     = {1'b0, exact} - {1'b0, approx_i};
      s1_ed_d  = diff[33] ? 33'(-diff) : diff[32:0];
      s1_v_d   = take;
      s2_v_d   = s1_v_q;
      sum_w    = {1'b0, sum_q} + (ACC_W+1)'(s1_ed_q);
      n_d      = start_ok ? num_samples_i : n_q;
      acc_d    = start_ok ? '0 : acc_q + 16'(take);
      cnt_d    = start_ok ? '0 : cnt_q + 16'(s1_v_q);
      err_d    = start_ok ? '0 : err_q + 16'(s1_v_q && s1_ed_q != '0);
      max_d    = start_ok ? '0 : (s1_v_q && s1_ed_q > max_q) ? s1_ed_q : max_q;
      sum_d    = start_ok ? '0 : !s1_v_q ? sum_q : sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
   end
endmodule

// File: tb/tb_approx_adder_error_monitor32.sv
// tb_approx_adder_error_monitor32: randomized and directed windows checked
// against an arithmetic model of the error statistics (48- and 34-bit sums).
module tb_approx_adder_error_monitor32;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0;
   logic [15:0] num = '0;
   logic [31:0] a = '0, b = '0;
   logic [32:0] ap = '0;
   logic ready, busy, done, ready34, busy34, done34;
   logic [15:0] cnt, err, cnt34, err34;
   logic [32:0] mx, mx34;
   logic [47:0] sum;
   logic [33:0] sum34;
   int checks = 0, errors = 0;
   logic [31:0] qa[$], qb[$];
   logic [32:0] qp[$];

   always #5 clk = ~clk;

   approx_adder_error_monitor32 dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_samples_i(num),
      .valid_i(valid), .ready_o(ready), .add1_i(a), .add2_i(b), .approx_i(ap),
      .sample_cnt_o(cnt), .err_cnt_o(err), .max_ed_o(mx), .sum_ed_o(sum),
      .busy_o(busy), .done_o(done));

   approx_adder_error_monitor32 #(.ACC_W(34)) dut34 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_samples_i(num),
      .valid_i(valid), .ready_o(ready34), .add1_i(a), .add2_i(b), .approx_i(ap),
      .sample_cnt_o(cnt34), .err_cnt_o(err34), .max_ed_o(mx34), .sum_ed_o(sum34),
      .busy_o(busy34), .done_o(done34));

   function automatic longint unsigned ed_of(logic [31:0] x, logic [31:0] y, logic [32:0] p);
      longint d;
      d = longint'({32'd0, x}) + longint'({32'd0, y}) - longint'({31'd0, p});
      return (d < 0) ? longint'(-d) : d;
   endfunction

   function automatic longint unsigned sat(longint unsigned v, int w);
      longint unsigned lim;
      lim = (64'd1 << w) - 64'd1;
      return (v > lim) ? lim : v;
   endfunction

   task automatic push(logic [31:0] x, logic [31:0] y, logic [32:0] p);
      qa.push_back(x); qb.push_back(y); qp.push_back(p);
   endtask

   task automatic push_random();
      logic [31:0] x, y;
      logic [32:0] e, p;
      x = $urandom; y = $urandom;
      e = {1'b0, x} + {1'b0, y};
      case ($urandom_range(0, 3))
         0: p = e;
         1: p = e + 33'($urandom_range(1, 300));
         2: p = e - 33'($urandom_range(1, 300));
         default: p = {1'($urandom_range(0, 1)), 32'($urandom)};
      endcase
      push(x, y, p);
   endtask

   // gap: 0 = valid every cycle, 1 = every other cycle, 2 = random
   task automatic run_window(input int n, input int gap, input bit poke, input string tag);
      int idx, cyc, nerr;
      longint unsigned e, emax, s48, s34;
      bit poked;
      idx = 0; cyc = 0; nerr = 0; emax = 0; s48 = 0; s34 = 0; poked = 0;
      for (int i = 0; i < n; i++) begin
         e = ed_of(qa[i], qb[i], qp[i]);
         if (e != 0) nerr++;
         if (e > emax) emax = e;
         s48 = sat(s48 + e, 48);
         s34 = sat(s34 + e, 34);
      end
      @(negedge clk); start = 1'b1; num = 16'(n); valid = 1'b0;
      @(negedge clk); start = 1'b0;
      while (idx < n && cyc < 400) begin
         valid = (gap == 0) ? 1'b1 : (gap == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 2) != 0);
         a = qa[idx]; b = qb[idx]; ap = qp[idx];
         if (poke && idx == 1 && !poked) begin
            start = 1'b1; num = 16'd1; poked = 1;
         end else start = 1'b0;
         if (valid && ready) idx++;
         cyc++;
         @(negedge clk);
      end
      valid = 1'b0; start = 1'b0;
      checks++;
      if (idx != n) begin errors++; $display("FAIL %s accepted: got %0d exp %0d", tag, idx, n); end
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL %s ready_after_last: ready %b busy %b exp ready 0 busy 1", tag, ready, busy);
      end
      if (gap == 0) begin
         checks++;
         if (cyc != n) begin errors++; $display("FAIL %s throughput: cycles %0d exp %0d", tag, cyc, n); end
      end
      for (int k = 0; k < 8 && done !== 1'b1; k++) @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s done: done %b busy %b exp 1 0", tag, done, busy); end
      checks++;
      if (cnt !== 16'(n)) begin errors++; $display("FAIL %s sample_cnt: got %0d exp %0d", tag, cnt, n); end
      checks++;
      if (err !== 16'(nerr)) begin errors++; $display("FAIL %s err_cnt: got %0d exp %0d", tag, err, nerr); end
      checks++;
      if (mx !== emax[32:0]) begin errors++; $display("FAIL %s max_ed: got %h exp %h", tag, mx, emax[32:0]); end
      checks++;
      if (sum !== s48[47:0]) begin errors++; $display("FAIL %s sum_ed48: got %h exp %h", tag, sum, s48[47:0]); end
      checks++;
      if (sum34 !== s34[33:0] || cnt34 !== 16'(n)) begin
         errors++; $display("FAIL %s sum_ed34: got %h cnt %0d exp %h cnt %0d", tag, sum34, cnt34, s34[33:0], n);
      end
      qa.delete(); qb.delete(); qp.delete();
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({ready, busy, done, ready34, busy34, done34} !== 6'b0 || cnt !== '0 || err !== '0 ||
          mx !== '0 || sum !== '0 || cnt34 !== '0 || err34 !== '0 || mx34 !== '0 || sum34 !== '0) begin
         errors++;
         $display("FAIL %s zero: rdy %b busy %b done %b cnt %0d err %0d max %h sum %h sum34 %h exp all 0",
                  tag, ready, busy, done, cnt, err, mx, sum, sum34);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("idle");
   endtask

   task automatic test_single();
      push(32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEFF);
      run_window(1, 0, 0, "single");
      checks++;
      if (mx !== 33'h13 || sum !== 48'h13 || err !== 16'd1) begin
         errors++; $display("FAIL single_const: max %h sum %h err %0d exp 13 13 1", mx, sum, err);
      end
   endtask

   task automatic test_exact();
      push(32'h0, 32'h0, 33'h0);
      push(32'h55555555, 32'hAAAAAAAA, 33'h0FFFFFFFF);
      push(32'hFFFFFFFF, 32'h00000001, 33'h100000000);
      run_window(3, 0, 0, "exact");
   endtask

   task automatic test_gaps();
      push(32'd10, 32'd0, 33'd5);
      push(32'd1, 32'd2, 33'd3);
      push(32'hFFFFFFFF, 32'd1, 33'd0);
      push(32'd0, 32'd0, 33'd7);
      run_window(4, 1, 0, "gaps");
      checks++;
      if (mx !== 33'h100000000 || sum !== 48'h10000000C || err !== 16'd3) begin
         errors++; $display("FAIL gaps_const: max %h sum %h err %0d exp 100000000 10000000c 3", mx, sum, err);
      end
   endtask

   task automatic test_zero();
      @(negedge clk); start = 1'b1; num = 16'd0;
      @(negedge clk); start = 1'b0;
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL zero_drain: busy %b ready %b exp 1 0", busy, ready); end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || cnt !== '0 || err !== '0 || mx !== '0 || sum !== '0) begin
         errors++; $display("FAIL zero_done: done %b cnt %0d err %0d max %h sum %h exp 1 0 0 0 0", done, cnt, err, mx, sum);
      end
   endtask

   task automatic test_start_ignored();
      for (int i = 0; i < 3; i++) push_random();
      run_window(3, 0, 1, "start_in_run");
   endtask

   task automatic test_reset_mid();
      @(negedge clk); start = 1'b1; num = 16'd3;
      @(negedge clk); start = 1'b0; valid = 1'b1; a = 32'd10; b = 32'd0; ap = 33'd1;
      @(negedge clk); valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid");
      repeat (3) @(negedge clk);
      check_all_zero("reset_mid_later");
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) push_random();
      run_window(12, 0, 0, "back_to_back");
   endtask

   task automatic test_random();
      for (int w = 0; w < 6; w++) begin
         int n;
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) push_random();
         run_window(n, 2, 0, "random");
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 3; i++) push(32'd0, 32'd0, 33'h1FFFFFFFF);
      run_window(3, 0, 0, "saturate");
      checks++;
      if (sum34 !== 34'h3FFFFFFFF || sum !== 48'h5FFFFFFFD || mx34 !== 33'h1FFFFFFFF) begin
         errors++; $display("FAIL saturate_const: sum34 %h sum48 %h max %h exp 3ffffffff 5fffffffd 1ffffffff", sum34, sum, mx34);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_exact();
      test_gaps();
      test_zero();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
